// File: rtl/iir_biquad_cascade_axis.sv
// iir_biquad_cascade_axis: N-channel, M-stage cascaded IIR biquad filter.
// One time-shared MAC, AXI-Stream samples, AXI-Lite coefficients and status.
module iir_biquad_cascade_axis #(
  parameter int NUM_CH     = 2,
  parameter int NUM_STAGES = 2,
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 18,
  parameter int COEF_FRAC  = 14,
  parameter int ADDR_W     = 8
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [NUM_CH*DATA_W-1:0]   s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  output logic [NUM_CH*DATA_W-1:0]   m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  input  logic [ADDR_W-1:0]          s_axi_awaddr,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,
  input  logic [31:0]                s_axi_wdata,
  input  logic [3:0]                 s_axi_wstrb,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,
  output logic [1:0]                 s_axi_bresp,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  input  logic [ADDR_W-1:0]          s_axi_araddr,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  output logic [31:0]                s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready
);

  localparam int NSEC   = NUM_STAGES * NUM_CH;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + 3;
  localparam int SW     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IW     = (NSEC > 1) ? $clog2(NSEC) : 1;

  localparam logic [SW-1:0] ST_LAST = SW'(NUM_STAGES - 1);
  localparam logic [CW-1:0] CH_LAST = CW'(NUM_CH - 1);
  localparam logic signed [COEF_W-1:0] ONE =
    COEF_W'(1) << COEF_FRAC;
  localparam logic signed [ACC_W-1:0] HALF =
    ACC_W'(1) << (COEF_FRAC - 1);
  localparam logic signed [ACC_W-1:0] MAXV =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t state;

  logic signed [COEF_W-1:0] coef [NUM_STAGES][5];
  logic signed [DATA_W-1:0] x1 [NSEC];
  logic signed [DATA_W-1:0] x2 [NSEC];
  logic signed [DATA_W-1:0] y1 [NSEC];
  logic signed [DATA_W-1:0] y2 [NSEC];
  logic signed [DATA_W-1:0] samp [NUM_CH];

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [ACC_W-1:0]  rnd;
  logic signed [ACC_W-1:0]  shf;
  logic signed [PROD_W-1:0] prod;
  logic signed [DATA_W-1:0] opd;
  logic signed [COEF_W-1:0] cf;
  logic signed [DATA_W-1:0] ysat;
  logic                     clip;

  logic [SW-1:0] stg;
  logic [CW-1:0] chn;
  logic [2:0]    ph;
  logic [IW-1:0] sec;
  logic          last_q;
  logic [NUM_CH*DATA_W-1:0] pack;

  logic enable;
  logic sat;
  logic busy;
  logic soft_clr;
  logic clip_now;

  assign busy = (state != IDLE);
  assign sec  = IW'(int'(stg) * NUM_CH + int'(chn));

  assign s_axis_tready = (state == IDLE) &&
    (enable || !m_axis_tvalid || m_axis_tready);

  // Operand/coefficient select for the shared multiplier
  always_comb begin
    opd = samp[chn];
    cf  = coef[stg][0];
    unique case (ph)
      3'd0: begin opd = samp[chn]; cf = coef[stg][0]; end
      3'd1: begin opd = x1[sec];   cf = coef[stg][1]; end
      3'd2: begin opd = x2[sec];   cf = coef[stg][2]; end
      3'd3: begin opd = y1[sec];   cf = coef[stg][3]; end
      3'd4: begin opd = y2[sec];   cf = coef[stg][4]; end
      default: ;
    endcase
  end

  assign prod    = opd * cf;
  assign acc_nxt = (ph > 3'd2) ? acc - ACC_W'(prod)
                               : acc + ACC_W'(prod);
  assign rnd     = acc + HALF;
  assign shf     = rnd >>> COEF_FRAC;

  always_comb begin
    ysat = shf[DATA_W-1:0];
    clip = 1'b0;
    if (shf > MAXV) begin
      ysat = {1'b0, {(DATA_W-1){1'b1}}};
      clip = 1'b1;
    end else if (shf < MINV) begin
      ysat = {1'b1, {(DATA_W-1){1'b0}}};
      clip = 1'b1;
    end
  end

  assign clip_now = (state == CALC) && (ph == 3'd5) && clip;

  always_comb begin
    pack = '0;
    for (int i = 0; i < NUM_CH; i++)
      pack[(NUM_CH-1-i)*DATA_W +: DATA_W] = samp[i];
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= IDLE;
      stg           <= '0;
      chn           <= '0;
      ph            <= '0;
      acc           <= '0;
      last_q        <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) samp[i] <= '0;
      for (int i = 0; i < NSEC; i++) begin
        x1[i] <= '0;
        x2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (m_axis_tvalid && m_axis_tready)
            m_axis_tvalid <= 1'b0;
          if (s_axis_tvalid && s_axis_tready) begin
            if (enable) begin
              for (int i = 0; i < NUM_CH; i++)
                samp[i] <= s_axis_tdata[(NUM_CH-1-i)*DATA_W +: DATA_W];
              last_q <= s_axis_tlast;
              stg    <= '0;
              chn    <= '0;
              ph     <= '0;
              acc    <= '0;
              state  <= CALC;
            end else begin
              m_axis_tdata  <= s_axis_tdata;
              m_axis_tlast  <= s_axis_tlast;
              m_axis_tvalid <= 1'b1;
            end
          end
        end
        CALC: begin
          if (ph != 3'd5) begin
            acc <= acc_nxt;
            ph  <= ph + 3'd1;
          end else begin
            x2[sec]   <= x1[sec];
            x1[sec]   <= samp[chn];
            y2[sec]   <= y1[sec];
            y1[sec]   <= ysat;
            samp[chn] <= ysat;
            acc       <= '0;
            ph        <= '0;
            if (chn == CH_LAST) begin
              chn <= '0;
              if (stg == ST_LAST) begin
                stg   <= '0;
                state <= OUT;
              end else begin
                stg <= stg + 1'b1;
              end
            end else begin
              chn <= chn + 1'b1;
            end
          end
        end
        OUT: begin
          if (!m_axis_tvalid) begin
            m_axis_tdata  <= pack;
            m_axis_tlast  <= last_q;
            m_axis_tvalid <= 1'b1;
          end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (soft_clr) begin
        for (int i = 0; i < NSEC; i++) begin
          x1[i] <= '0;
          x2[i] <= '0;
          y1[i] <= '0;
          y2[i] <= '0;
        end
      end
    end
  end

  logic [ADDR_W-1:0] aw_off;
  logic [ADDR_W-1:0] ar_off;
  logic [ADDR_W-6:0] aw_stage;
  logic [ADDR_W-6:0] ar_stage;
  logic [2:0]        aw_k;
  logic [2:0]        ar_k;
  logic aw_ctrl, aw_stat, aw_coef;
  logic ar_ctrl, ar_stat, ar_coef;
  logic hold, wr_fire;
  logic [31:0] coef_rd;
  logic [31:0] rd_mux;

  assign aw_off   = s_axi_awaddr - ADDR_W'(64);
  assign ar_off   = s_axi_araddr - ADDR_W'(64);
  assign aw_stage = aw_off[ADDR_W-1:5];
  assign ar_stage = ar_off[ADDR_W-1:5];
  assign aw_k     = aw_off[4:2];
  assign ar_k     = ar_off[4:2];

  assign aw_ctrl = (s_axi_awaddr == '0);
  assign aw_stat = (s_axi_awaddr == ADDR_W'(4));
  assign aw_coef = (s_axi_awaddr >= ADDR_W'(64)) &&
    (s_axi_awaddr[1:0] == 2'b00) && (aw_k < 3'd5) &&
    (aw_stage < (ADDR_W-5)'(NUM_STAGES));
  assign ar_ctrl = (s_axi_araddr == '0);
  assign ar_stat = (s_axi_araddr == ADDR_W'(4));
  assign ar_coef = (s_axi_araddr >= ADDR_W'(64)) &&
    (s_axi_araddr[1:0] == 2'b00) && (ar_k < 3'd5) &&
    (ar_stage < (ADDR_W-5)'(NUM_STAGES));

  // A sample accepted this cycle counts as busy for config writes
  assign hold = (aw_ctrl || aw_coef) &&
    (busy || (enable && s_axis_tvalid && s_axis_tready));
  assign wr_fire  = s_axi_awready && s_axi_awvalid && s_axi_wvalid;
  assign soft_clr = wr_fire && aw_ctrl && s_axi_wdata[1];

  assign s_axi_bresp = 2'b00;
  assign s_axi_rresp = 2'b00;

  always_comb begin
    coef_rd = '0;
    for (int s = 0; s < NUM_STAGES; s++)
      for (int k = 0; k < 5; k++)
        if (int'(ar_stage) == s && int'(ar_k) == k)
          coef_rd = 32'(coef[s][k]);
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      ar_ctrl: rd_mux = {31'd0, enable};
      ar_stat: rd_mux = {30'd0, busy, sat};
      ar_coef: rd_mux = coef_rd;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      enable        <= 1'b0;
      sat           <= 1'b0;
      for (int s = 0; s < NUM_STAGES; s++) begin
        coef[s][0] <= ONE;
        for (int k = 1; k < 5; k++) coef[s][k] <= '0;
      end
    end else begin
      s_axi_awready <= !s_axi_awready && s_axi_awvalid &&
        s_axi_wvalid && !s_axi_bvalid && !hold;
      s_axi_wready  <= !s_axi_awready && s_axi_awvalid &&
        s_axi_wvalid && !s_axi_bvalid && !hold;
      if (wr_fire) s_axi_bvalid <= 1'b1;
      else if (s_axi_bready) s_axi_bvalid <= 1'b0;
      if (wr_fire && aw_ctrl) enable <= s_axi_wdata[0];
      if (wr_fire && aw_stat && s_axi_wdata[0]) sat <= 1'b0;
      if (clip_now) sat <= 1'b1;
      if (wr_fire && aw_coef) begin
        for (int s = 0; s < NUM_STAGES; s++)
          for (int k = 0; k < 5; k++)
            if (int'(aw_stage) == s && int'(aw_k) == k)
              coef[s][k] <= s_axi_wdata[COEF_W-1:0];
      end
      s_axi_arready <= !s_axi_arready && s_axi_arvalid &&
        !s_axi_rvalid;
      if (s_axi_arready && s_axi_arvalid) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_mux;
      end else if (s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

  logic unused;
  assign unused = ^{s_axi_wstrb, s_axi_wdata[31:COEF_W],
                    aw_off[1:0], ar_off[1:0]};

endmodule

// File: tb/tb_iir_biquad_cascade_axis.sv
// tb_iir_biquad_cascade_axis: directed vectors for the biquad cascade,
// expected values worked out by hand at default parameters.
`timescale 1ns/1ps
module tb_iir_biquad_cascade_axis;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic [7:0]  s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = 4'hF;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b1;
  logic [7:0]  s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b1;

  iir_biquad_cascade_axis dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready)
  );

  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_wr(input logic [7:0] addr, input logic [31:0] data);
    logic ok;
    ok = 1'b0;
    @(negedge aclk);
    s_axi_awaddr = addr;
    s_axi_wdata = data;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge aclk);
      if (s_axi_awready) begin ok = 1'b1; break; end
    end
    @(posedge aclk);
    #1;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid = 1'b0;
    if (!ok) check("aw_timeout", {31'd0, ok}, 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      if (s_axi_bvalid) begin ok = 1'b1; break; end
    end
    if (!ok) check("b_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic axi_rd(input logic [7:0] addr, output logic [31:0] data);
    logic ok;
    ok = 1'b0;
    data = 'x;
    @(negedge aclk);
    s_axi_araddr = addr;
    s_axi_arvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (s_axi_arready) begin ok = 1'b1; break; end
    end
    @(posedge aclk);
    #1;
    s_axi_arvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      if (s_axi_rvalid) begin data = s_axi_rdata; break; end
    end
    if (!ok) check("ar_timeout", {31'd0, ok}, 32'd1);
  endtask

  // Handshake one beat, then count edges until the output beat shows up
  task automatic send(input logic [31:0] d, input logic l,
                      output logic [31:0] od, output logic ol,
                      output int lat);
    @(negedge aclk);
    s_axis_tdata = d;
    s_axis_tlast = l;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (s_axis_tready) break;
      @(negedge aclk);
    end
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    lat = 0;
    while (!m_axis_tvalid && lat < 60) begin
      @(posedge aclk);
      #1;
      lat++;
    end
    od = m_axis_tdata;
    ol = m_axis_tlast;
    @(posedge aclk);
    #1;
  endtask

  logic [31:0] d;
  logic        l;
  int          lat;
  int          aw_hi;
  int          beats;
  logic        ok;
  logic [31:0] hd;
  logic        hl;

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("rst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_s_tready", {31'd0, s_axis_tready}, 32'd1);
    check("rst_m_tdata", m_axis_tdata, 32'd0);
    check("rst_awready", {31'd0, s_axi_awready}, 32'd0);
    axi_rd(8'h00, d);
    check("rst_ctrl", d, 32'd0);
    axi_rd(8'h40, d);
    check("rst_b0", d, 32'd16384);
    axi_rd(8'h90, d);
    check("unmapped_rd", d, 32'd0);

    send(32'h1234ABCD, 1'b0, d, l, lat);
    check("byp_data", d, 32'h1234ABCD);
    check("byp_lat", lat, 32'd0);
    check("byp_last", {31'd0, l}, 32'd0);

    axi_wr(8'h00, 32'd1);
    axi_rd(8'h00, d);
    check("ctrl_en", d, 32'd1);
    send(32'h03E8FC18, 1'b1, d, l, lat);
    check("id_data", d, 32'h03E8FC18);
    check("id_lat", lat, 32'd25);
    check("id_last", {31'd0, l}, 32'd1);

    axi_wr(8'h00, 32'd3);
    axi_rd(8'h00, d);
    check("ctrl_clr_rd", d, 32'd1);
    axi_wr(8'h40, 32'd8192);
    axi_wr(8'h44, 32'd8192);
    send(32'h03E80000, 1'b0, d, l, lat);
    check("fir_y0", d, 32'h01F40000);
    send(32'h00000000, 1'b0, d, l, lat);
    check("fir_y1", d, 32'h01F40000);
    send(32'h00000000, 1'b0, d, l, lat);
    check("fir_y2", d, 32'h00000000);

    axi_wr(8'h00, 32'd3);
    axi_wr(8'h40, 32'd32767);
    axi_wr(8'h44, 32'd0);
    axi_wr(8'h60, 32'd32767);
    axi_rd(8'h04, d);
    check("sat_pre", d, 32'd0);
    send(32'h75300000, 1'b0, d, l, lat);
    check("sat_data", d, 32'h7FFF0000);
    axi_rd(8'h04, d);
    check("sat_flag", d, 32'd1);
    axi_wr(8'h04, 32'd1);
    axi_rd(8'h04, d);
    check("sat_w1c", d, 32'd0);

    axi_wr(8'h40, 32'd16384);
    axi_wr(8'h60, 32'd16384);
    axi_wr(8'h4C, 32'hFFFFE000);
    axi_rd(8'h4C, d);
    check("a1_rd", d, 32'hFFFFE000);
    axi_wr(8'h00, 32'd3);
    send(32'h03E80000, 1'b0, d, l, lat);
    check("iir_y0", d, 32'h03E80000);
    send(32'h00000000, 1'b0, d, l, lat);
    check("iir_y1", d, 32'h01F40000);
    axi_wr(8'h00, 32'd3);
    send(32'h00000000, 1'b0, d, l, lat);
    check("iir_clr", d, 32'h00000000);

    axi_wr(8'h00, 32'd3);
    @(negedge aclk);
    m_axis_tready = 1'b0;
    s_axis_tdata = 32'h03E807D0;
    s_axis_tlast = 1'b1;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (s_axis_tready) break;
      @(negedge aclk);
    end
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    lat = 0;
    aw_hi = 0;
    while (!m_axis_tvalid && lat < 60) begin
      if (lat == 3) begin
        s_axi_awaddr = 8'h68;
        s_axi_wdata = 32'd0;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid = 1'b1;
      end
      @(posedge aclk);
      #1;
      lat++;
      if (s_axi_awready) aw_hi++;
    end
    check("hold_lat", lat, 32'd25);
    check("calc_awready", aw_hi, 32'd0);
    hd = m_axis_tdata;
    hl = m_axis_tlast;
    check("hold_data0", hd, 32'h03E807D0);
    for (int i = 0; i < 10; i++) begin
      @(posedge aclk);
      #1;
      check("hold_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
      check("hold_tdata", m_axis_tdata, hd);
      check("hold_tlast", {31'd0, m_axis_tlast}, {31'd0, hl});
      check("hold_s_tready", {31'd0, s_axis_tready}, 32'd0);
      check("hold_awready", {31'd0, s_axi_awready}, 32'd0);
    end
    m_axis_tready = 1'b1;
    @(posedge aclk);
    #1;
    check("hold_drain", {31'd0, m_axis_tvalid}, 32'd0);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      if (s_axi_awready) begin ok = 1'b1; break; end
    end
    @(posedge aclk);
    #1;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid = 1'b0;
    check("late_aw_done", {31'd0, ok}, 32'd1);
    repeat (2) @(posedge aclk);

    axi_wr(8'h00, 32'd3);
    send(32'h03E80000, 1'b1, d, l, lat);
    check("pre_rst_beat", d, 32'h03E80000);
    @(negedge aclk);
    s_axis_tdata = 32'h03E80000;
    s_axis_tvalid = 1'b1;
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    repeat (5) @(posedge aclk);
    #1;
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    check("rst_mid_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_mid_tready", {31'd0, s_axis_tready}, 32'd1);
    aresetn = 1'b1;
    beats = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge aclk);
      #1;
      if (m_axis_tvalid) beats++;
    end
    check("rst_no_beat", beats, 32'd0);
    axi_rd(8'h00, d);
    check("rst2_ctrl", d, 32'd0);
    axi_rd(8'h4C, d);
    check("rst2_a1", d, 32'd0);
    axi_rd(8'h40, d);
    check("rst2_b0", d, 32'd16384);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iir_biquad_cascade_axis.md
Name: iir_biquad_cascade_axis

Overview:
Parametrised successor to the stereo biquad: an N-channel, M-stage cascaded IIR biquad filter with AXI-Stream sample I/O and AXI-Lite control and status. Each stage has its own AXI-Lite programmable coefficient set.
A single time-multiplexed multiplier executes every (stage, channel) section sequentially, with rounding, saturation, a sticky overflow flag, bypass and soft clear.
It sits in the audio chain between the stream source (I2S/DMA) and downstream DSP.

Parameters:
NUM_CH, 2, channels packed per stream beat
NUM_STAGES, 2, cascaded biquad sections (1..6, limited by the address map)
DATA_W, 16, signed sample width per channel
COEF_W, 18, signed coefficient width
COEF_FRAC, 14, coefficient fractional bits (1.0 = 2^COEF_FRAC)
ADDR_W, 8, AXI-Lite address width

Ports:
aclk  in  1  clock
aresetn  in  1  reset, synchronous, active-low
s_axis_tdata  in  NUM_CH*DATA_W  input samples; ch0 in the MSBs
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  frame marker
m_axis_tdata  out  NUM_CH*DATA_W  filtered samples, same packing as input
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  tlast of the corresponding input beat
s_axi_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  write address channel
s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel; wstrb ignored
s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response; bresp always OKAY
s_axi_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  read address channel
s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel; rresp always OKAY

Behaviour:
- Reset (aresetn low at a posedge), also mid-operation: all outputs 0 except s_axis_tready=1.
  - Reset clears CTRL, STATUS and all section state.
  - Coefficients reset to identity: b0=2^COEF_FRAC; b1, b2, a1, a2 = 0.
  - An in-flight sample is discarded.
- Register map:
  - 0x00 CTRL: bit0 enable (R/W); bit1 soft clear, write-1 pulse, reads 0.
  - 0x04 STATUS: bit0 sticky saturation (write 1 to clear); bit1 busy (RO).
  - 0x40 + s*0x20 + k*4 for stage s, k=0..4 = b0, b1, b2, a1, a2.
  - Coefficient writes take wdata[COEF_W-1:0]; reads sign-extend to 32 bits.
  - Unmapped addresses: writes ignored, reads return 0.
- AXI-Lite write:
  - awready and wready pulse together for one cycle when awvalid & wvalid & !bvalid.
  - bvalid is held until bready.
  - Writes to CTRL or to coefficients are held off (ready low) while busy, so a sample never sees mixed coefficients.
- AXI-Lite read: arready pulses when arvalid & !rvalid; rdata and rvalid appear the next cycle and are held until rready.
- Bypass (enable=0):
  - Output register pass-through; s_axis_tready = !m_axis_tvalid | m_axis_tready.
  - Latency 1 cycle, full throughput, section state untouched.
- Filter mode, FSM IDLE -> CALC -> OUT:
  - IDLE: s_axis_tready=1; on handshake capture tdata and tlast, go to CALC, busy=1.
  - CALC: stage-major, then channel order. Each section takes 6 cycles: 5 multiply-accumulate cycles plus 1 writeback.
  - Section equation: acc = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2 at full precision (DATA_W+COEF_W+3 bits).
  - y = (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC, then saturated to DATA_W. Any clip sets STATUS bit0.
  - Writeback: x2<=x1, x1<=x, y2<=y1, y1<=y (saturated values). Stage s output feeds stage s+1 of the same channel.
  - OUT: m_axis_tvalid=1; tdata and tlast stable until m_axis_tready; then back to IDLE with busy=0.
  - s_axis_tready=0 in CALC and OUT.
- Latency: m_axis_tvalid rises 1 + 6*NUM_STAGES*NUM_CH cycles after the input handshake edge (25 cycles at defaults).
- Soft clear: zeroes all x1, x2, y1, y2 the cycle after the write handshake; coefficients and enable are unchanged.
- Enable toggle: takes effect only between samples, because CTRL writes are held off while busy.

Test Plan:
- Reset defaults -> CTRL reads 0x0 and stage0 b0 reads 16384. Bypass beat 0x1234ABCD -> m_axis_tdata 0x1234ABCD one cycle later.
- Enable with identity coefficients; send ch0=1000, ch1=-1000 with tlast=1 -> the same values and tlast=1 exactly 25 cycles after the handshake.
- Stage0 b0=b1=8192, stage1 identity; send impulse 1000 then zeros on ch0 -> outputs 500, 500, 0; ch1 with zero input stays 0.
- Stage0 and stage1 b0=32767; input 30000 -> output 32767 and STATUS bit0=1. Write 0x1 to STATUS -> reads 0.
- Stage0 a1=-8192; impulse 1000 -> 1000, 500. Then soft clear and zero input -> output 0 (no 250 tail).
  - A coefficient write issued mid-CALC sees awready held low until the sample completes.
- Hold m_axis_tready low for 10 cycles at OUT -> tvalid, tdata and tlast stay stable and s_axis_tready stays 0. Assert aresetn low mid-CALC -> no output beat appears.
